csr_file_param: RTL and testbench

- Parametrised machine-mode CSR file for the RV32 core datapath. Supersedes the fixed csr_top/csr_reg pair.
- Adds:
  - a configurable number of local (platform) interrupt lines with fixed-priority arbitration;
  - direct/vectored mtvec;
  - 64-bit mcycle/minstret counters with mcountinhibit;
  - illegal-access flagging;
  - a registered interrupt request/acknowledge handshake with the pipeline.
- Sits beside the register file. The decode/trap controller drives it; the PC mux consumes trap_pc and mepc.

---
 rtl/csr_pkg.sv | 51 +++++
 rtl/csr_irq_arb.sv | 67 ++++++
 rtl/csr_file_param.sv | 184 ++++++++++++++++++
 tb/tb_csr_file_param.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, command encoding,
// cause codes and mstatus bit positions.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MCOUNTINH = 12'h320;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    typedef enum logic [1:0] {
        CSR_RO = 2'b00,
        CSR_W  = 2'b01,
        CSR_S  = 2'b10,
        CSR_C  = 2'b11
    } csr_cmd_e;

    localparam logic [4:0] CAUSE_MSI    = 5'd3;
    localparam logic [4:0] CAUSE_MTI    = 5'd7;
    localparam logic [4:0] CAUSE_MEI    = 5'd11;
    localparam int         LOCAL_BASE   = 16;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    localparam logic [31:0] MSTATUS_RST = 32'h0000_1800;
    localparam logic [31:0] MISA_VAL    = 32'h4000_0100;

    function automatic logic [31:0] csr_apply(input csr_cmd_e cmd, input logic [31:0] old_v,
                                              input logic [31:0] wd);
        case (cmd)
            CSR_W:   csr_apply = wd;
            CSR_S:   csr_apply = old_v | wd;
            CSR_C:   csr_apply = old_v & ~wd;
            default: csr_apply = old_v;
        endcase
    endfunction

endpackage

// File: rtl/csr_irq_arb.sv
// Registers the interrupt sources into mip and picks the highest-priority
// enabled one; irq_req and its cause code are registered together.
module csr_irq_arb
    import csr_pkg::*;
#(
    parameter int NUM_LIRQ = 4
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    irq_ext,
    input  logic                                    irq_timer,
    input  logic                                    irq_sw,
    input  logic [((NUM_LIRQ > 0) ? NUM_LIRQ : 1)-1:0] irq_local,
    input  logic [31:0]                             mie_i,
    input  logic                                    gie_i,
    input  logic                                    clr_i,
    output logic [31:0]                             mip_o,
    output logic                                    irq_req_o,
    output logic [4:0]                              irq_code_o
);

    logic [31:0] src, mip_q, pend;
    logic [4:0]  code_d, code_q;
    logic        req_d, req_q;

    always_comb begin
        src            = '0;
        src[CAUSE_MSI] = irq_sw;
        src[CAUSE_MTI] = irq_timer;
        src[CAUSE_MEI] = irq_ext;
        for (int i = 0; i < NUM_LIRQ; i++) src[LOCAL_BASE+i] = irq_local[i];
    end

    assign pend = mip_q & mie_i;

    // Downward scan so the lowest-numbered local line wins.
    always_comb begin
        code_d = CAUSE_MEI;
        if (pend[CAUSE_MEI])      code_d = CAUSE_MEI;
        else if (pend[CAUSE_MSI]) code_d = CAUSE_MSI;
        else if (pend[CAUSE_MTI]) code_d = CAUSE_MTI;
        else begin
            for (int i = NUM_LIRQ - 1; i >= 0; i--)
                if (pend[LOCAL_BASE+i]) code_d = 5'(LOCAL_BASE + i);
        end
    end

    // Dropping the request on trap entry stops a second acknowledge before MIE clears.
    assign req_d = (|pend) & gie_i & ~clr_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            mip_q  <= '0;
            req_q  <= 1'b0;
            code_q <= '0;
        end else begin
            mip_q  <= src;
            req_q  <= req_d;
            code_q <= code_d;
        end
    end

    assign mip_o      = mip_q;
    assign irq_req_o  = req_q;
    assign irq_code_o = code_q;

endmodule

// File: rtl/csr_file_param.sv
// Machine-mode CSR file: CSR read/modify/write, trap entry/exit, counters and
// the registered interrupt request toward the pipeline.
module csr_file_param
    import csr_pkg::*;
#(
    parameter int          NUM_LIRQ     = 4,
    parameter bit          HAS_COUNTERS = 1'b1,
    parameter logic [31:0] RESET_MTVEC  = 32'h0000_0000,
    parameter logic [31:0] HART_ID      = 32'd0
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    csr_en,
    input  logic [1:0]                              csr_cmd,
    input  logic [11:0]                             csr_addr,
    input  logic [31:0]                             wdata,
    output logic [31:0]                             rdata,
    output logic                                    illegal,
    input  logic                                    exp_valid,
    input  logic [4:0]                              exp_code,
    input  logic                                    int_ack,
    input  logic                                    ret_valid,
    input  logic                                    instr_retire,
    input  logic [31:0]                             current_pc,
    input  logic                                    irq_ext,
    input  logic                                    irq_timer,
    input  logic                                    irq_sw,
    input  logic [((NUM_LIRQ > 0) ? NUM_LIRQ : 1)-1:0] irq_local,
    output logic                                    irq_req,
    output logic                                    trap_taken,
    output logic [31:0]                             trap_pc,
    output logic [31:0]                             mepc,
    output logic                                    mstatus_mie
);

    localparam logic [31:0] MIE_MASK = 32'h0000_0888 | (((32'h1 << NUM_LIRQ) - 32'h1) << 16);

    logic        gie_q, gie_d, mpie_q, mpie_d;
    logic [31:0] mie_q, mie_d, mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d;
    logic [31:0] mscratch_q, mscratch_d, minh_q, minh_d;
    logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
    logic [31:0] mip, csr_rd, wres, mtvec_base;
    logic [4:0]  irq_code;
    logic        implemented, read_only, int_take, mret_en, wr_en;
    csr_cmd_e    cmd;

    assign cmd = csr_cmd_e'(csr_cmd);

    csr_irq_arb #(.NUM_LIRQ(NUM_LIRQ)) u_arb (
        .clk       (clk),
        .reset     (reset),
        .irq_ext   (irq_ext),
        .irq_timer (irq_timer),
        .irq_sw    (irq_sw),
        .irq_local (irq_local),
        .mie_i     (mie_q),
        .gie_i     (gie_q),
        .clr_i     (trap_taken),
        .mip_o     (mip),
        .irq_req_o (irq_req),
        .irq_code_o(irq_code)
    );

    always_comb begin
        csr_rd      = '0;
        implemented = 1'b1;
        read_only   = 1'b0;
        case (csr_addr)
            CSR_MSTATUS:   csr_rd = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, gie_q, 3'b0};
            CSR_MISA:      begin csr_rd = MISA_VAL; read_only = 1'b1; end
            CSR_MIE:       csr_rd = mie_q;
            CSR_MTVEC:     csr_rd = mtvec_q;
            CSR_MCOUNTINH: csr_rd = minh_q;
            CSR_MSCRATCH:  csr_rd = mscratch_q;
            CSR_MEPC:      csr_rd = mepc_q;
            CSR_MCAUSE:    csr_rd = mcause_q;
            CSR_MIP:       begin csr_rd = mip; read_only = 1'b1; end
            CSR_MCYCLE:    csr_rd = mcycle_q[31:0];
            CSR_MCYCLEH:   csr_rd = mcycle_q[63:32];
            CSR_MINSTRET:  csr_rd = minstret_q[31:0];
            CSR_MINSTRETH: csr_rd = minstret_q[63:32];
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: read_only = 1'b1;
            CSR_MHARTID:   begin csr_rd = HART_ID; read_only = 1'b1; end
            default:       implemented = 1'b0;
        endcase
    end

    assign rdata      = csr_rd;
    assign illegal    = csr_en & (~implemented | ((cmd != CSR_RO) & read_only));
    assign int_take   = int_ack & irq_req & ~exp_valid;
    assign trap_taken = exp_valid | (int_ack & irq_req);
    assign mret_en    = ret_valid & ~trap_taken;
    assign wr_en      = csr_en & (cmd != CSR_RO) & ~illegal & ~trap_taken & ~ret_valid;
    assign wres       = csr_apply(cmd, csr_rd, wdata);

    assign mtvec_base = {mtvec_q[31:2], 2'b00};
    assign trap_pc    = (!exp_valid && mtvec_q[1:0] == 2'b01)
                      ? mtvec_base + {25'b0, irq_code, 2'b00} : mtvec_base;

    always_comb begin
        gie_d      = gie_q;
        mpie_d     = mpie_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mscratch_d = mscratch_q;
        minh_d     = minh_q;
        mcycle_d   = minh_q[0] ? mcycle_q : mcycle_q + 64'd1;
        minstret_d = (instr_retire && !minh_q[2]) ? minstret_q + 64'd1 : minstret_q;

        // A write to one counter half replaces the increment for the whole counter.
        if (wr_en) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    gie_d  = wres[MSTATUS_MIE];
                    mpie_d = wres[MSTATUS_MPIE];
                end
                CSR_MIE:       mie_d      = wres & MIE_MASK;
                CSR_MTVEC:     mtvec_d    = wres & ~32'h2;
                CSR_MCOUNTINH: minh_d     = wres & 32'h5;
                CSR_MSCRATCH:  mscratch_d = wres;
                CSR_MEPC:      mepc_d     = wres & ~32'h3;
                CSR_MCAUSE:    mcause_d   = wres;
                CSR_MCYCLE:    mcycle_d   = {mcycle_q[63:32], wres};
                CSR_MCYCLEH:   mcycle_d   = {wres, mcycle_q[31:0]};
                CSR_MINSTRET:  minstret_d = {minstret_q[63:32], wres};
                CSR_MINSTRETH: minstret_d = {wres, minstret_q[31:0]};
                default: ;
            endcase
        end

        if (exp_valid) begin
            mepc_d   = current_pc;
            mcause_d = {27'b0, exp_code};
            mpie_d   = gie_q;
            gie_d    = 1'b0;
        end else if (int_take) begin
            mepc_d   = current_pc;
            mcause_d = {1'b1, 26'b0, irq_code};
            mpie_d   = gie_q;
            gie_d    = 1'b0;
        end else if (mret_en) begin
            gie_d    = mpie_q;
            mpie_d   = 1'b1;
        end

        if (!HAS_COUNTERS) begin
            minh_d     = '0;
            mcycle_d   = '0;
            minstret_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mie_q      <= '0;
            mtvec_q    <= RESET_MTVEC;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mscratch_q <= '0;
            minh_q     <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            gie_q      <= gie_d;
            mpie_q     <= mpie_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mscratch_q <= mscratch_d;
            minh_q     <= minh_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    assign mepc        = mepc_q;
    assign mstatus_mie = gie_q;

endmodule

// File: tb/tb_csr_file_param.sv
// Scoreboard bench for csr_file_param: expected CSR read results are queued as
// each access is driven and popped when the combinational result is sampled.
module tb_csr_file_param;

    localparam int          NL   = 4;
    localparam logic [31:0] RMTV = 32'h0000_0100;
    localparam logic [31:0] HID  = 32'd3;

    logic          clk = 1'b0;
    logic          reset, csr_en, exp_valid, int_ack, ret_valid, instr_retire;
    logic          irq_ext, irq_timer, irq_sw;
    logic [1:0]    csr_cmd;
    logic [11:0]   csr_addr;
    logic [31:0]   wdata, current_pc;
    logic [4:0]    exp_code;
    logic [NL-1:0] irq_local;
    logic [31:0]   rdata, trap_pc, mepc;
    logic          illegal, irq_req, trap_taken, mstatus_mie;

    always #5 clk = ~clk;

    csr_file_param #(.NUM_LIRQ(NL), .HAS_COUNTERS(1'b1), .RESET_MTVEC(RMTV), .HART_ID(HID)) dut (
        .clk(clk), .reset(reset), .csr_en(csr_en), .csr_cmd(csr_cmd), .csr_addr(csr_addr),
        .wdata(wdata), .rdata(rdata), .illegal(illegal), .exp_valid(exp_valid),
        .exp_code(exp_code), .int_ack(int_ack), .ret_valid(ret_valid),
        .instr_retire(instr_retire), .current_pc(current_pc), .irq_ext(irq_ext),
        .irq_timer(irq_timer), .irq_sw(irq_sw), .irq_local(irq_local), .irq_req(irq_req),
        .trap_taken(trap_taken), .trap_pc(trap_pc), .mepc(mepc), .mstatus_mie(mstatus_mie)
    );

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        ill;
        logic        chk_d;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] rd_v;
    logic        ill_v;

    // Every task starts and ends 1 time unit after a rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic csr_op(input logic [1:0] cmd, input logic [11:0] addr, input logic [31:0] wd);
        csr_en = 1'b1; csr_cmd = cmd; csr_addr = addr; wdata = wd;
        #4;
        rd_v = rdata; ill_v = illegal;
        @(posedge clk); #1;
        csr_en = 1'b0; csr_cmd = 2'b00;
    endtask

    // Pops and compares the oldest queued expectation against the last sampled access.
    task automatic sb_pop();
        exp_t e;
        e = sb.pop_front();
        checks++;
        if ((e.chk_d && rd_v !== e.data) || ill_v !== e.ill) begin
            errors++;
            $display("FAIL %s: rdata=%h illegal=%b, expected rdata=%h illegal=%b",
                     e.name, rd_v, ill_v, e.data, e.ill);
        end
    endtask

    task automatic rd_chk(input string nm, input logic [11:0] addr, input logic [31:0] exp_d);
        sb.push_back('{nm, exp_d, 1'b0, 1'b1});
        csr_op(2'b00, addr, 32'h0);
        sb_pop();
    endtask

    task automatic test_reset();
        logic [11:0] a [5];
        logic [31:0] d [5];
        a = '{12'h300, 12'h305, 12'h344, 12'hF14, 12'h301};
        d = '{32'h0000_1800, RMTV, 32'h0, HID, 32'h4000_0100};
        for (int i = 0; i < 5; i++) rd_chk($sformatf("reset_read_%h", a[i]), a[i], d[i]);
        sb.push_back('{"reset_unimpl_7C0", 32'h0, 1'b1, 1'b0});
        csr_op(2'b00, 12'h7C0, 32'h0);
        sb_pop();
        checks++;
        if (irq_req !== 1'b0 || mstatus_mie !== 1'b0 || mepc !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: irq_req=%b mie=%b mepc=%h, expected 0 0 0",
                     irq_req, mstatus_mie, mepc);
        end
    endtask

    task automatic test_masks();
        csr_op(2'b01, 12'h341, 32'h0000_1233);
        csr_op(2'b01, 12'h305, 32'hFFFF_FFFF);
        csr_op(2'b01, 12'h304, 32'hFFFF_FFFF);
        csr_op(2'b01, 12'h300, 32'hFFFF_FFFF);
        rd_chk("mask_mepc", 12'h341, 32'h0000_1230);
        rd_chk("mask_mtvec", 12'h305, 32'hFFFF_FFFD);
        rd_chk("mask_mie", 12'h304, 32'h000F_0888);
        rd_chk("mask_mstatus", 12'h300, 32'h0000_1888);
        sb.push_back('{"clear_prewrite_mtvec", 32'hFFFF_FFFD, 1'b0, 1'b1});
        csr_op(2'b11, 12'h305, 32'hFFFF_FFF0);
        sb_pop();
        rd_chk("clear_mtvec", 12'h305, 32'h0000_000D);
        csr_op(2'b01, 12'h300, 32'h0);
        csr_op(2'b01, 12'h304, 32'h0);
    endtask

    task automatic test_illegal();
        csr_op(2'b01, 12'h340, 32'h0000_0055);
        sb.push_back('{"illegal_clr_mhartid", HID, 1'b1, 1'b1});
        csr_op(2'b11, 12'hF14, 32'h0000_00FF);
        sb_pop();
        sb.push_back('{"illegal_wr_misa", 32'h4000_0100, 1'b1, 1'b1});
        csr_op(2'b01, 12'h301, 32'h0);
        sb_pop();
        sb.push_back('{"illegal_set_mip", 32'h0, 1'b1, 1'b1});
        csr_op(2'b10, 12'h344, 32'h0000_0888);
        sb_pop();
        sb.push_back('{"illegal_wr_unimpl", 32'h0, 1'b1, 1'b0});
        csr_op(2'b01, 12'h7C0, 32'h1234);
        sb_pop();
        rd_chk("mhartid_unchanged", 12'hF14, HID);
        rd_chk("mip_unchanged", 12'h344, 32'h0);
        rd_chk("mscratch_legal_wr", 12'h340, 32'h0000_0055);
    endtask

    task automatic test_local_irq();
        csr_op(2'b01, 12'h305, 32'h0000_1001);
        csr_op(2'b01, 12'h304, 32'h0001_0000);
        csr_op(2'b10, 12'h300, 32'h0000_0008);
        irq_local = 4'b0001;
        tick(1);
        checks++;
        if (irq_req !== 1'b0) begin
            errors++; $display("FAIL irq_latency_1: irq_req=%b expected 0", irq_req);
        end
        tick(1);
        checks++;
        if (irq_req !== 1'b1) begin
            errors++; $display("FAIL irq_latency_2: irq_req=%b expected 1", irq_req);
        end
        rd_chk("mip_local0", 12'h344, 32'h0001_0000);
        int_ack = 1'b1; current_pc = 32'h100;
        #4;
        checks++;
        if (trap_taken !== 1'b1 || trap_pc !== 32'h0000_1040) begin
            errors++;
            $display("FAIL local_trap_pc: taken=%b pc=%h expected 1 00001040", trap_taken, trap_pc);
        end
        @(posedge clk); #1;
        int_ack = 1'b0; irq_local = '0;
        checks++;
        if (irq_req !== 1'b0 || mstatus_mie !== 1'b0 || mepc !== 32'h100) begin
            errors++;
            $display("FAIL local_entry: irq_req=%b mie=%b mepc=%h expected 0 0 00000100",
                     irq_req, mstatus_mie, mepc);
        end
        rd_chk("local_mcause", 12'h342, 32'h8000_0010);
        rd_chk("local_mstatus", 12'h300, 32'h0000_1880);
    endtask

    task automatic test_priority();
        csr_op(2'b01, 12'h304, 32'h0001_0888);
        irq_ext = 1'b1; irq_timer = 1'b1;
        csr_op(2'b10, 12'h300, 32'h0000_0008);
        tick(2);
        checks++;
        if (irq_req !== 1'b1) begin
            errors++; $display("FAIL prio_req: irq_req=%b expected 1", irq_req);
        end
        int_ack = 1'b1; current_pc = 32'h200;
        #4;
        checks++;
        if (trap_pc !== 32'h0000_102C) begin
            errors++; $display("FAIL prio_trap_pc: pc=%h expected 0000102c", trap_pc);
        end
        @(posedge clk); #1;
        int_ack = 1'b0;
        rd_chk("prio_mcause_mei", 12'h342, 32'h8000_000B);
        // mret restores MIE from MPIE and leaves mepc alone
        ret_valid = 1'b1;
        tick(1);
        ret_valid = 1'b0;
        checks++;
        if (mstatus_mie !== 1'b1 || mepc !== 32'h200) begin
            errors++;
            $display("FAIL mret: mie=%b mepc=%h expected 1 00000200", mstatus_mie, mepc);
        end
        rd_chk("mret_mstatus", 12'h300, 32'h0000_1888);
        // exception + interrupt ack + CSR write in one cycle: exception wins, write dropped
        exp_valid = 1'b1; exp_code = 5'd2; int_ack = 1'b1; current_pc = 32'h300;
        csr_en = 1'b1; csr_cmd = 2'b01; csr_addr = 12'h340; wdata = 32'h0000_DEAD;
        #4;
        checks++;
        if (trap_taken !== 1'b1 || trap_pc !== 32'h0000_1000) begin
            errors++;
            $display("FAIL exc_trap_pc: taken=%b pc=%h expected 1 00001000", trap_taken, trap_pc);
        end
        @(posedge clk); #1;
        exp_valid = 1'b0; int_ack = 1'b0; csr_en = 1'b0; csr_cmd = 2'b00;
        rd_chk("exc_mcause", 12'h342, 32'h0000_0002);
        rd_chk("exc_mepc", 12'h341, 32'h0000_0300);
        rd_chk("exc_write_dropped", 12'h340, 32'h0000_0055);
        rd_chk("exc_mstatus", 12'h300, 32'h0000_1880);
        // MSI outranks MTI
        irq_ext = 1'b0; irq_sw = 1'b1;
        csr_op(2'b10, 12'h300, 32'h0000_0008);
        tick(2);
        int_ack = 1'b1; current_pc = 32'h400;
        #4;
        checks++;
        if (trap_taken !== 1'b1 || trap_pc !== 32'h0000_100C) begin
            errors++;
            $display("FAIL msi_trap_pc: taken=%b pc=%h expected 1 0000100c", trap_taken, trap_pc);
        end
        @(posedge clk); #1;
        int_ack = 1'b0; irq_sw = 1'b0; irq_timer = 1'b0;
        rd_chk("msi_mcause", 12'h342, 32'h8000_0003);
        tick(3);
        int_ack = 1'b1;
        #4;
        checks++;
        if (trap_taken !== 1'b0) begin
            errors++; $display("FAIL ack_no_req: taken=%b expected 0", trap_taken);
        end
        @(posedge clk); #1;
        int_ack = 1'b0;
        rd_chk("ack_no_req_mcause", 12'h342, 32'h8000_0003);
    endtask

    task automatic test_counters();
        csr_op(2'b01, 12'hB00, 32'hFFFF_FFFF);
        csr_op(2'b01, 12'hB80, 32'h0);
        tick(1);
        rd_chk("mcycleh_carry", 12'hB80, 32'h1);
        rd_chk("mcycle_low", 12'hB00, 32'h1);
        sb.push_back('{"minh_prewrite", 32'h0, 1'b0, 1'b1});
        csr_op(2'b10, 12'h320, 32'h1);
        sb_pop();
        rd_chk("mcycle_inhibit_a", 12'hB00, 32'h3);
        tick(3);
        rd_chk("mcycle_inhibit_b", 12'hB00, 32'h3);
        rd_chk("mcycleh_inhibit", 12'hB80, 32'h1);
        instr_retire = 1'b1;
        tick(3);
        instr_retire = 1'b0;
        rd_chk("minstret_count", 12'hB02, 32'h3);
        rd_chk("minstreth_count", 12'hB82, 32'h0);
        csr_op(2'b01, 12'hB02, 32'hFFFF_FFFF);
        csr_op(2'b01, 12'hB82, 32'hFFFF_FFFF);
        rd_chk("minstret_allones", 12'hB02, 32'hFFFF_FFFF);
        instr_retire = 1'b1;
        tick(1);
        instr_retire = 1'b0;
        rd_chk("minstret_wrap_lo", 12'hB02, 32'h0);
        rd_chk("minstret_wrap_hi", 12'hB82, 32'h0);
    endtask

    task automatic test_reset_mid();
        csr_op(2'b10, 12'h300, 32'h0000_0008);
        irq_ext = 1'b1;
        tick(2);
        checks++;
        if (irq_req !== 1'b1) begin
            errors++; $display("FAIL midreset_pre: irq_req=%b expected 1", irq_req);
        end
        reset = 1'b1;
        tick(1);
        reset = 1'b0; irq_ext = 1'b0;
        checks++;
        if (irq_req !== 1'b0 || mstatus_mie !== 1'b0 || mepc !== 32'h0) begin
            errors++;
            $display("FAIL midreset_outputs: irq_req=%b mie=%b mepc=%h expected 0 0 0",
                     irq_req, mstatus_mie, mepc);
        end
        rd_chk("midreset_mtvec", 12'h305, RMTV);
        rd_chk("midreset_mie", 12'h304, 32'h0);
        rd_chk("midreset_minh", 12'h320, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; csr_en = 1'b0; csr_cmd = 2'b00; csr_addr = '0; wdata = '0;
        exp_valid = 1'b0; exp_code = '0; int_ack = 1'b0; ret_valid = 1'b0;
        instr_retire = 1'b0; current_pc = '0; irq_ext = 1'b0; irq_timer = 1'b0;
        irq_sw = 1'b0; irq_local = '0;
        tick(2);
        reset = 1'b0;
        test_reset();
        test_masks();
        test_illegal();
        test_local_irq();
        test_priority();
        test_counters();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
